// File: rtl/difftest_step_batcher.sv
// Batches per-cycle difftest commit counts into `step` values so the downstream
// nstep DPI is called less often; stops stepping once a non-zero result arrives.
module difftest_step_batcher #(
  parameter int STEP_WIDTH      = 8,
  parameter int IN_WIDTH        = 4,
  parameter int ACC_WIDTH       = 16,
  parameter int BATCH_THRESHOLD = 16,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  commit_valid,
  input  logic [IN_WIDTH-1:0]   commit_cnt,
  input  logic                  flush,
  input  logic [7:0]            simv_result,
  output logic [STEP_WIDTH-1:0] step,
  output logic [ACC_WIDTH-1:0]  pending,
  output logic                  halted,
  output logic                  overflow
);
  localparam int SW = ACC_WIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [SW-1:0] MAXS     = {{(SW-STEP_WIDTH){1'b0}}, {STEP_WIDTH{1'b1}}};
  localparam logic [SW-1:0] ACC_MAX  = {1'b0, {ACC_WIDTH{1'b1}}};
  localparam logic [SW-1:0] THRESH   = SW'(BATCH_THRESHOLD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [ACC_WIDTH-1:0]  pending_q, pending_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  overflow_q, overflow_d;

  logic [SW-1:0]         add_s;
  logic [SW-1:0]         sum_s;
  logic [SW-1:0]         rem_s;
  logic [STEP_WIDTH-1:0] emit_val_s;
  logic                  emit_s;
  logic                  halt_req_s;

  // Clamp a widened count into the accumulator range.
  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [SW-1:0] v);
    logic [ACC_WIDTH-1:0] r;
    if (v > ACC_MAX) begin
      r = {ACC_WIDTH{1'b1}};
    end else begin
      r = v[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  // Shared arithmetic for this cycle: sum, clamped emit value, remainder, triggers.
  always_comb begin
    add_s = commit_valid ? SW'(commit_cnt) : {SW{1'b0}};
    sum_s = {1'b0, pending_q} + add_s;
    if (sum_s > MAXS) begin
      emit_val_s = {STEP_WIDTH{1'b1}};
    end else begin
      emit_val_s = sum_s[STEP_WIDTH-1:0];
    end
    rem_s      = sum_s - SW'(emit_val_s);
    halt_req_s = (simv_result != 8'h00);
    emit_s     = (sum_s >= THRESH)
              || ((timer_q == TMO_LAST) && (sum_s != {SW{1'b0}}))
              || (flush && (sum_s != {SW{1'b0}}));
  end

  // Next-state logic; a pending halt request beats any emit in the same cycle.
  always_comb begin
    state_d    = state_q;
    step_d     = {STEP_WIDTH{1'b0}};
    pending_d  = pending_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (halt_req_s) begin
          state_d    = ST_HALT;
          pending_d  = sat_acc(sum_s);
          overflow_d = overflow_q | (sum_s > ACC_MAX);
        end else if ((state_q == ST_DRAIN) || emit_s) begin
          step_d     = emit_val_s;
          pending_d  = sat_acc(rem_s);
          overflow_d = overflow_q | (rem_s > ACC_MAX);
          timer_d    = {TW{1'b0}};
          if (state_q == ST_DRAIN) begin
            state_d = (rem_s == {SW{1'b0}}) ? ST_RUN : ST_DRAIN;
          end else if (flush && (rem_s != {SW{1'b0}})) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          pending_d  = sat_acc(sum_s);
          overflow_d = overflow_q | (sum_s > ACC_MAX);
          timer_d    = (sum_s == {SW{1'b0}}) ? {TW{1'b0}} : timer_q + TW'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // An illegal encoding stops stepping rather than risk spurious steps.
        state_d = ST_HALT;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      step_q     <= {STEP_WIDTH{1'b0}};
      pending_q  <= {ACC_WIDTH{1'b0}};
      timer_q    <= {TW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  assign step     = step_q;
  assign pending  = pending_q;
  assign halted   = (state_q == ST_HALT);
  assign overflow = overflow_q;

endmodule
